tag_lookup_ctrl: RTL and testbench

TAG_LOOKUP_CTRL -- requirements
Module: tag_lookup_ctrl

---
 rtl/tag_lookup_ctrl.sv | 176 +++++++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_ctrl.sv
// Two-stage way-halting tag lookup controller.
// The 4-bit halt tag of each way is compared first. When no valid way
// passes, the lookup ends early as a miss. Otherwise only the surviving
// ways get a full 20-bit main tag compare. Hit, miss and early-miss
// statistics are kept in saturating counters.
module tag_lookup_ctrl #(
   parameter int CNT_W = 16,
   parameter int NWAYS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [31:0]          req_addr,
   output logic [3:0]           rd_index,
   input  logic [4*NWAYS-1:0]   halt_tag_in,
   input  logic [20*NWAYS-1:0]  main_tag_in,
   input  logic [NWAYS-1:0]     way_valid_in,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 resp_hit,
   output logic [1:0]           resp_way,
   output logic                 resp_multi,
   output logic [CNT_W-1:0]     hit_cnt,
   output logic [CNT_W-1:0]     miss_cnt,
   output logic [CNT_W-1:0]     halt_cnt
);

   typedef enum logic [1:0] {IDLE, HALT_CMP, MAIN_CMP, RESP} state_t;

   state_t             state_q, state_d;
   logic [3:0]         halt_tag_q, halt_tag_d;
   logic [19:0]        main_tag_q, main_tag_d;
   logic [3:0]         rd_index_q, rd_index_d;
   logic [NWAYS-1:0]   halt_match_q, halt_match_d;
   logic               req_ready_q, req_ready_d;
   logic               resp_valid_q, resp_valid_d;
   logic               resp_hit_q, resp_hit_d;
   logic [1:0]         resp_way_q, resp_way_d;
   logic               resp_multi_q, resp_multi_d;
   logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
   logic [CNT_W-1:0]   halt_cnt_q, halt_cnt_d;
   logic [NWAYS-1:0]   full_match;
   logic [2:0]         match_cnt;
   logic [1:0]         first_way;

   // The byte offset does not take part in the lookup.
   logic unused_offset;
   assign unused_offset = ^req_addr[3:0];

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Next-state logic: tags are captured on accept, the array inputs are only
   // looked at in the two compare states, and results are held through RESP.
   always_comb begin
      state_d      = state_q;
      halt_tag_d   = halt_tag_q;
      main_tag_d   = main_tag_q;
      rd_index_d   = rd_index_q;
      halt_match_d = halt_match_q;
      resp_valid_d = resp_valid_q;
      resp_hit_d   = resp_hit_q;
      resp_way_d   = resp_way_q;
      resp_multi_d = resp_multi_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      halt_cnt_d   = halt_cnt_q;
      full_match   = '0;
      match_cnt    = 3'd0;
      first_way    = 2'd0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               halt_tag_d = req_addr[11:8];
               main_tag_d = req_addr[31:12];
               rd_index_d = req_addr[7:4];
               state_d    = HALT_CMP;
            end
         end
         HALT_CMP: begin
            for (int w = 0; w < NWAYS; w++) begin
               halt_match_d[w] = way_valid_in[w] & (halt_tag_in[4*w +: 4] == halt_tag_q);
            end
            if (halt_match_d == '0) begin
               resp_hit_d   = 1'b0;
               resp_way_d   = 2'd0;
               resp_multi_d = 1'b0;
               miss_cnt_d   = sat_inc(miss_cnt_q);
               halt_cnt_d   = sat_inc(halt_cnt_q);
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else begin
               state_d = MAIN_CMP;
            end
         end
         MAIN_CMP: begin
            for (int w = NWAYS - 1; w >= 0; w--) begin
               full_match[w] = halt_match_q[w] & (main_tag_in[20*w +: 20] == main_tag_q);
               if (full_match[w]) begin
                  first_way = 2'(w);
                  match_cnt = match_cnt + 3'd1;
               end
            end
            if (full_match != '0) begin
               resp_hit_d   = 1'b1;
               resp_way_d   = first_way;
               resp_multi_d = (match_cnt > 3'd1);
               hit_cnt_d    = sat_inc(hit_cnt_q);
            end else begin
               resp_hit_d   = 1'b0;
               resp_way_d   = 2'd0;
               resp_multi_d = 1'b0;
               miss_cnt_d   = sat_inc(miss_cnt_q);
            end
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
   end

   // State and registered outputs; reset abandons any lookup in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         halt_tag_q   <= '0;
         main_tag_q   <= '0;
         rd_index_q   <= '0;
         halt_match_q <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_way_q   <= 2'd0;
         resp_multi_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         halt_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         halt_tag_q   <= halt_tag_d;
         main_tag_q   <= main_tag_d;
         rd_index_q   <= rd_index_d;
         halt_match_q <= halt_match_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         resp_way_q   <= resp_way_d;
         resp_multi_q <= resp_multi_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         halt_cnt_q   <= halt_cnt_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign rd_index   = rd_index_q;
   assign resp_valid = resp_valid_q;
   assign resp_hit   = resp_hit_q;
   assign resp_way   = resp_way_q;
   assign resp_multi = resp_multi_q;
   assign hit_cnt    = hit_cnt_q;
   assign miss_cnt   = miss_cnt_q;
   assign halt_cnt   = halt_cnt_q;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Testbench for tag_lookup_ctrl: a set-associative tag store model feeds the
// array inputs, expected responses are queued at issue and a monitor checks
// them, their latency, stability under backpressure and the counters.
module tb_tag_lookup_ctrl;

   localparam int CNT_W = 4;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [31:0]       req_addr = '0;
   logic [3:0]        rd_index;
   logic [15:0]       halt_tag_in;
   logic [79:0]       main_tag_in;
   logic [3:0]        way_valid_in;
   logic              resp_valid;
   logic              resp_ready = 1'b0;
   logic              resp_hit;
   logic [1:0]        resp_way;
   logic              resp_multi;
   logic [CNT_W-1:0]  hit_cnt, miss_cnt, halt_cnt;

   tag_lookup_ctrl #(.CNT_W(CNT_W), .NWAYS(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rd_index(rd_index), .halt_tag_in(halt_tag_in), .main_tag_in(main_tag_in),
      .way_valid_in(way_valid_in),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_hit(resp_hit), .resp_way(resp_way), .resp_multi(resp_multi),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .halt_cnt(halt_cnt)
   );

   always #5 clk = ~clk;

   int cycle_cnt = 0;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // Tag store contents, one entry per set and way.
   logic [3:0]  mem_halt  [16][4];
   logic [19:0] mem_main  [16][4];
   logic        mem_valid [16][4];

   // When junk_en is set the arrays present garbage, which the DUT must ignore.
   logic        junk_en = 1'b0;
   logic [15:0] junk_halt = '0;
   logic [79:0] junk_main = '0;
   logic [3:0]  junk_valid = '0;

   // Combinational array read at the DUT's index, or garbage.
   always_comb begin
      halt_tag_in  = '0;
      main_tag_in  = '0;
      way_valid_in = '0;
      if (junk_en) begin
         halt_tag_in  = junk_halt;
         main_tag_in  = junk_main;
         way_valid_in = junk_valid;
      end else begin
         for (int w = 0; w < 4; w++) begin
            halt_tag_in[4*w +: 4]   = mem_halt[rd_index][w];
            main_tag_in[20*w +: 20] = mem_main[rd_index][w];
            way_valid_in[w]         = mem_valid[rd_index][w];
         end
      end
   end

   typedef struct {
      int hit;
      int way;
      int multi;
      int lat;
      int hc;
      int mc;
      int hlc;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_hit = 0, m_miss = 0, m_halt = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic randomizeJunk();
      junk_halt  = 16'($urandom);
      junk_main  = {16'($urandom), 32'($urandom), 32'($urandom)};
      junk_valid = 4'($urandom);
   endtask

   task automatic setWay(input int idx, input int w, input logic v, input logic [3:0] ht, input logic [19:0] mt);
      mem_valid[idx][w] = v;
      mem_halt[idx][w]  = ht;
      mem_main[idx][w]  = mt;
   endtask

   function automatic int satInc(input int v);
      return (v < MAXC) ? v + 1 : v;
   endfunction

   // Reference: two-level match over the addressed set, counters bumped per lookup.
   task automatic predict(input logic [31:0] a, output exp_t e);
      int idx, nh, nf, fw;
      idx = int'(a[7:4]);
      nh = 0; nf = 0; fw = 0;
      for (int w = 0; w < 4; w++) begin
         if (mem_valid[idx][w] && mem_halt[idx][w] == a[11:8]) begin
            nh++;
            if (mem_main[idx][w] == a[31:12]) begin
               if (nf == 0) fw = w;
               nf++;
            end
         end
      end
      if (nh == 0) begin
         e.hit = 0; e.way = 0; e.multi = 0; e.lat = 2;
         m_miss = satInc(m_miss);
         m_halt = satInc(m_halt);
      end else if (nf > 0) begin
         e.hit = 1; e.way = fw; e.multi = (nf > 1) ? 1 : 0; e.lat = 3;
         m_hit = satInc(m_hit);
      end else begin
         e.hit = 0; e.way = 0; e.multi = 0; e.lat = 3;
         m_miss = satInc(m_miss);
      end
      e.hc = m_hit; e.mc = m_miss; e.hlc = m_halt; e.acc = 0;
   endtask

   // Issue one lookup, hold backpressure for 'hold' RESP cycles while a stray
   // request is offered, then release the response.
   task automatic applyStimulus(input logic [31:0] a, input int hold);
      exp_t e;
      int   t;
      predict(a, e);
      @(negedge clk);
      randomizeJunk();
      junk_en   = 1'b1;
      req_addr  = a;
      req_valid = 1'b1;
      t = 0;
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         checkOutput("accept_timeout", {31'd0, req_ready}, 32'd1);
         req_valid = 1'b0;
         junk_en   = 1'b0;
         return;
      end
      e.acc = cycle_cnt;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      junk_en   = 1'b0;
      checkOutput("rd_index", {28'd0, rd_index}, {28'd0, a[7:4]});
      t = 0;
      while (!resp_valid && t < 10) begin
         @(negedge clk);
         t++;
      end
      if (!resp_valid) begin
         checkOutput("resp_timeout", {31'd0, resp_valid}, 32'd1);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         randomizeJunk();
         junk_en   = 1'b1;
         req_valid = 1'b1;
         req_addr  = $urandom;
         @(negedge clk);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      junk_en    = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      junk_en    = 1'b0;
      checkOutput("resp_drop", {31'd0, resp_valid}, 32'd0);
      checkOutput("ready_after_resp", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_req_ready"},  {31'd0, req_ready}, 32'd1);
      checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      checkOutput({tag, "_resp_hit"},   {31'd0, resp_hit}, 32'd0);
      checkOutput({tag, "_resp_way"},   {30'd0, resp_way}, 32'd0);
      checkOutput({tag, "_resp_multi"}, {31'd0, resp_multi}, 32'd0);
      checkOutput({tag, "_rd_index"},   {28'd0, rd_index}, 32'd0);
      checkOutput({tag, "_hit_cnt"},    32'(hit_cnt), 32'd0);
      checkOutput({tag, "_miss_cnt"},   32'(miss_cnt), 32'd0);
      checkOutput({tag, "_halt_cnt"},   32'(halt_cnt), 32'd0);
   endtask

   // Start a main-stage lookup and pull reset while it is in the main compare.
   task automatic resetMidLookup(input logic [31:0] a);
      @(negedge clk);
      req_addr  = a;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      m_hit = 0; m_miss = 0; m_halt = 0;
      checkResetState("mid_reset");
      repeat (5) @(negedge clk);
      checkOutput("mid_reset_no_resp", {31'd0, resp_valid}, 32'd0);
   endtask

   // Monitor: pop the expectation when a response appears, then keep it
   // stable while it is held.
   initial begin
      exp_t cur;
      logic prev_valid;
      logic have;
      prev_valid = 1'b0;
      have = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_resp", {31'd0, resp_valid}, 32'd0);
               have = 1'b0;
            end else begin
               cur = sb.pop_front();
               have = 1'b1;
               checkOutput("resp_hit",   {31'd0, resp_hit}, 32'(cur.hit));
               checkOutput("resp_way",   {30'd0, resp_way}, 32'(cur.way));
               checkOutput("resp_multi", {31'd0, resp_multi}, 32'(cur.multi));
               checkOutput("latency",    32'(cycle_cnt - cur.acc), 32'(cur.lat));
               checkOutput("hit_cnt",    32'(hit_cnt), 32'(cur.hc));
               checkOutput("miss_cnt",   32'(miss_cnt), 32'(cur.mc));
               checkOutput("halt_cnt",   32'(halt_cnt), 32'(cur.hlc));
            end
         end else if (resp_valid && have) begin
            checkOutput("hold_hit",   {31'd0, resp_hit}, 32'(cur.hit));
            checkOutput("hold_way",   {30'd0, resp_way}, 32'(cur.way));
            checkOutput("hold_multi", {31'd0, resp_multi}, 32'(cur.multi));
            checkOutput("hold_hit_cnt", 32'(hit_cnt), 32'(cur.hc));
         end
         if (resp_valid) checkOutput("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
         if (!resp_valid) have = 1'b0;
         prev_valid = resp_valid;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a;
      int          idx;
      logic [3:0]  ht;
      logic [19:0] mt;
      for (int s = 0; s < 16; s++)
         for (int w = 0; w < 4; w++) setWay(s, w, 1'b0, 4'd0, 20'd0);

      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkResetState("reset");
      reset = 1'b1;

      // Hit in way 2.
      setWay(5, 0, 1'b1, 4'h1, 20'hABCDE);
      setWay(5, 1, 1'b1, 4'h2, 20'hABCDE);
      setWay(5, 2, 1'b1, 4'h3, 20'hABCDE);
      setWay(5, 3, 1'b1, 4'h4, 20'hABCDE);
      applyStimulus(32'hABCDE350, 0);

      // Early miss: only an invalid way carries halt tag 3.
      setWay(5, 0, 1'b0, 4'h3, 20'hABCDE);
      setWay(5, 2, 1'b1, 4'h6, 20'hABCDE);
      applyStimulus(32'hABCDE357, 1);

      // Halt alias on way 1; fully matching way 0 is invalid.
      setWay(5, 1, 1'b1, 4'h3, 20'h00001);
      applyStimulus(32'hABCDE35C, 0);

      // Multi-match on ways 1 and 3 with five cycles of backpressure.
      setWay(5, 0, 1'b1, 4'h3, 20'h12345);
      setWay(5, 1, 1'b1, 4'h3, 20'hABCDE);
      setWay(5, 2, 1'b1, 4'h7, 20'hABCDE);
      setWay(5, 3, 1'b1, 4'h3, 20'hABCDE);
      applyStimulus(32'hABCDE351, 5);

      // Reset during the main compare.
      resetMidLookup(32'hABCDE351);

      // Drive the 4-bit hit counter into saturation.
      for (int i = 0; i < 18; i++) applyStimulus(32'hABCDE350, i % 3);

      // Randomised lookups over small tag pools so every outcome is common.
      for (int n = 0; n < 80; n++) begin
         idx = $urandom_range(15);
         ht  = 4'($urandom_range(3));
         mt  = 20'($urandom);
         a   = {mt, ht, 4'(idx), 4'($urandom)};
         for (int w = 0; w < 4; w++)
            setWay(idx, w, ($urandom_range(3) != 0), 4'($urandom_range(3)),
                   ($urandom_range(1) == 1) ? mt : (mt ^ 20'h00001));
         applyStimulus(a, $urandom_range(3));
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
